// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with a first-word-fall-through receive FIFO
module uart_receiver #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_BIT   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t           state;
    state_t           state_next;
    logic             sync_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             tick;
    logic             push_req;
    logic             ferr_req;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync_meta <= rx;
            rx_s      <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START:     if (tick) state_next = rx_s ? IDLE : DATA;
            DATA:      if (tick && bit_idx == 3'd7) state_next = STOP;
            STOP:      if (tick) state_next = rx_s ? IDLE : WAIT_IDLE;
            // a held-low line (break) must go high before a new start is accepted
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        tick     = (cnt == '0);
        busy     = (state != IDLE);
        push_req = (state == STOP) && tick && rx_s;
        ferr_req = (state == STOP) && tick && !rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: if (!rx_s) cnt <= CNT_HALF;
                START: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s) begin
                        cnt     <= CNT_BIT;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= CNT_BIT;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: if (!tick) cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    always_comb begin
        full     = (fifo_count == COUNT_MAX);
        rx_valid = (fifo_count != '0);
        rx_data  = mem[rd_ptr];
        do_pop   = rd_en && rx_valid;
        do_push  = push_req && (!full || do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            frame_err <= ferr_req;
            overrun   <= push_req && full && !do_pop;
        end
    end
endmodule
